// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: accept, execute, hold response.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win; the default build uses round-robin.
module alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the granted requester
  // EXEC  | operands registered and driving the ALU; result captured at exit
  // RESP  | response held until the consumer takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic        grant;
  logic        accept;
  logic        op_id_q;
  logic [31:0] op_src1_q, op_src2_q;
  logic [3:0]  op_ctrl_q;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;
  logic        ctrl_legal;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = !req0_valid_i;
  end
`else
  logic last_grant_q;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    if (req0_valid_i && req1_valid_i) grant = !last_grant_q;
    else                              grant = req1_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)      last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= grant;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          req0_ready_o = req0_valid_i && !grant;
          req1_ready_o = req1_valid_i && grant;
        end
        if (req0_ready_o || req1_ready_o) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = req0_ready_o || req1_ready_o;

  always_comb begin
    case (op_ctrl_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: ctrl_legal = 1'b1;
      default:                                     ctrl_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      op_id_q   <= 1'b0;
      op_src1_q <= '0;
      op_src2_q <= '0;
      op_ctrl_q <= '0;
    end else if (accept) begin
      op_id_q   <= grant;
      op_src1_q <= grant ? req1_src1_i : req0_src1_i;
      op_src2_q <= grant ? req1_src2_i : req0_src2_i;
      op_ctrl_q <= grant ? req1_ctrl_i : req0_ctrl_i;
    end
  end

  // Unknown op codes still complete, but report a zero result.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_result_q <= ctrl_legal ? alu_result_i : 32'd0;
      rsp_zero_q   <= alu_zero_i;
    end
  end

  assign alu_src1_o   = op_src1_q;
  assign alu_src2_o   = op_src2_q;
  assign alu_ctrl_o   = op_ctrl_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = op_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;

endmodule
